coin_acceptor: RTL and testbench



---
 rtl/coin_acceptor_if.sv | 23 ++
 rtl/coin_acceptor.sv | 138 +++++++++++++
 tb/tb_coin_acceptor.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/coin_acceptor_if.sv
// Sensor-side and controller-side signals of coin_acceptor, bundled for port use.
// The tally signal exists only when COIN_TALLY_EN is defined.
interface coin_acceptor_if;
  logic       coin_in_5;
  logic       coin_in_10;
  logic       coin;
  logic       coin_reject;
  logic [3:0] pending;
  logic       busy;
`ifdef COIN_TALLY_EN
  logic [15:0] tally;

  modport master (output coin_in_5, coin_in_10,
                  input  coin, coin_reject, pending, busy, tally);
  modport slave  (input  coin_in_5, coin_in_10,
                  output coin, coin_reject, pending, busy, tally);
`else
  modport master (output coin_in_5, coin_in_10,
                  input  coin, coin_reject, pending, busy);
  modport slave  (input  coin_in_5, coin_in_10,
                  output coin, coin_reject, pending, busy);
`endif
endinterface

// File: rtl/coin_acceptor.sv
// Coin-slot front end: synchronise, debounce, buffer credit and emit spaced 5-unit pulses.
// Optional feature macro: COIN_TALLY_EN adds a saturating 16-bit accepted-value tally.
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PULSE_GAP       = 4,
  parameter int MAX_PENDING     = 6
) (
  input  logic           clk,
  input  logic           reset,
  coin_acceptor_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PULSE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  localparam logic [7:0] DB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] GAP_LOAD = 4'(PULSE_GAP);
  localparam logic [4:0] MAX_P    = 5'(MAX_PENDING);

  // Bit 0 is the 5-unit slot, bit 1 the 10-unit slot.
  logic [1:0] w_raw;
  logic [1:0] r_sync1;
  logic [1:0] r_sync2;
  logic [1:0] r_level;
  logic [1:0] r_level_d;
  logic [1:0] r_rise;
  logic [7:0] r_db_cnt [2];

  logic [1:0] r_state;
  logic [3:0] r_gap_cnt;
  logic [3:0] r_pending;
  logic       r_coin;
  logic       r_reject;

  logic       w_dec;
  logic [4:0] w_base;
  logic [4:0] w_after10;
  logic [3:0] w_next;
  logic       w_acc10;
  logic       w_acc5;
  logic       w_reject;

  assign w_raw = {bus.coin_in_10, bus.coin_in_5};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_level   <= '0;
      r_level_d <= '0;
      r_rise    <= '0;
      for (int i = 0; i < 2; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1   <= w_raw;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      r_rise    <= r_level & ~r_level_d;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_level[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_level[i]  <= ~r_level[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 8'd1;
        end
      end
    end
  end

  // The 10-coin claims buffer space first; the 5-coin sees what is left.
  // NOTE: every signal gets a value on every path through always_comb, so no latch is inferred.
  always_comb begin
    w_dec     = (r_state == S_IDLE) && (r_pending != 4'd0);
    w_base    = {1'b0, r_pending} - {4'd0, w_dec};
    w_acc10   = r_rise[1] && ((w_base + 5'd2) <= MAX_P);
    w_after10 = w_base + (w_acc10 ? 5'd2 : 5'd0);
    w_acc5    = r_rise[0] && ((w_after10 + 5'd1) <= MAX_P);
    w_next    = 4'(w_after10 + {4'd0, w_acc5});
    w_reject  = (r_rise[1] && !w_acc10) || (r_rise[0] && !w_acc5);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_gap_cnt <= '0;
      r_pending <= '0;
      r_coin    <= 1'b0;
      r_reject  <= 1'b0;
    end else begin
      r_pending <= w_next;
      r_reject  <= w_reject;
      r_coin    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_dec) begin
            r_state <= S_PULSE;
            r_coin  <= 1'b1;
          end
        end
        S_PULSE: begin
          r_state   <= S_GAP;
          r_gap_cnt <= GAP_LOAD;
        end
        S_GAP: begin
          if (r_gap_cnt <= 4'd1) r_state <= S_IDLE;
          else                   r_gap_cnt <= r_gap_cnt - 4'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef COIN_TALLY_EN
  logic [15:0] r_tally;
  logic [3:0]  w_units;
  logic [16:0] w_tally_sum;

  always_comb begin
    w_units     = (w_acc10 ? 4'd10 : 4'd0) + (w_acc5 ? 4'd5 : 4'd0);
    w_tally_sum = {1'b0, r_tally} + {13'd0, w_units};
  end

  always_ff @(posedge clk) begin
    if (reset)               r_tally <= '0;
    else if (w_tally_sum[16]) r_tally <= 16'hFFFF;
    else                     r_tally <= w_tally_sum[15:0];
  end

  assign bus.tally = r_tally;
`endif

  assign bus.coin        = r_coin;
  assign bus.coin_reject = r_reject;
  assign bus.pending     = r_pending;
  assign bus.busy        = (r_pending != 4'd0) || (r_state != S_IDLE);
endmodule

// File: tb/tb_coin_acceptor.sv
// Scoreboarded bench for coin_acceptor: a default instance (debounce 16, gap 4) and a fast
// instance (debounce 1, gap 15) used to fill the buffer for overflow and simultaneous cases.
module tb_coin_acceptor;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  int exp_coin_a[$];
  int exp_rej_a[$];
  int exp_coin_b[$];
  int exp_rej_b[$];
  int e_a;
  int e_b;

  coin_acceptor_if bus_a ();
  coin_acceptor_if bus_b ();

  coin_acceptor #(.DEBOUNCE_CYCLES(16), .PULSE_GAP(4), .MAX_PENDING(6)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  coin_acceptor #(.DEBOUNCE_CYCLES(1), .PULSE_GAP(15), .MAX_PENDING(6)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard side: every observed pulse must match the oldest expected cycle.
  always @(negedge clk) begin
    if (bus_a.coin === 1'b1) begin
      checks++;
      if (exp_coin_a.size() == 0) begin
        errors++;
        $display("FAIL coin_a_unexpected: pulse at cycle %0d, none expected", cyc);
      end else begin
        e_a = exp_coin_a.pop_front();
        if (cyc != e_a) begin
          errors++;
          $display("FAIL coin_a_time: pulse at cycle %0d, expected cycle %0d", cyc, e_a);
        end
      end
    end
    if (bus_a.coin_reject === 1'b1) begin
      checks++;
      if (exp_rej_a.size() == 0) begin
        errors++;
        $display("FAIL reject_a_unexpected: reject at cycle %0d, none expected", cyc);
      end else begin
        e_a = exp_rej_a.pop_front();
        if (cyc != e_a) begin
          errors++;
          $display("FAIL reject_a_time: reject at cycle %0d, expected cycle %0d", cyc, e_a);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (bus_b.coin === 1'b1) begin
      checks++;
      if (exp_coin_b.size() == 0) begin
        errors++;
        $display("FAIL coin_b_unexpected: pulse at cycle %0d, none expected", cyc);
      end else begin
        e_b = exp_coin_b.pop_front();
        if (cyc != e_b) begin
          errors++;
          $display("FAIL coin_b_time: pulse at cycle %0d, expected cycle %0d", cyc, e_b);
        end
      end
    end
    if (bus_b.coin_reject === 1'b1) begin
      checks++;
      if (exp_rej_b.size() == 0) begin
        errors++;
        $display("FAIL reject_b_unexpected: reject at cycle %0d, none expected", cyc);
      end else begin
        e_b = exp_rej_b.pop_front();
        if (cyc != e_b) begin
          errors++;
          $display("FAIL reject_b_time: reject at cycle %0d, expected cycle %0d", cyc, e_b);
        end
      end
    end
  end

  task automatic wait_cycle(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus_a.coin_in_5 = 1'b0; bus_a.coin_in_10 = 1'b0;
    bus_b.coin_in_5 = 1'b0; bus_b.coin_in_10 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus_a.coin, bus_a.coin_reject, bus_a.busy, bus_a.pending} !== 7'd0) begin
      errors++;
      $display("FAIL reset_a: coin/rej/busy/pending %b, expected 0000000",
               {bus_a.coin, bus_a.coin_reject, bus_a.busy, bus_a.pending});
    end
    checks++;
    if ({bus_b.coin, bus_b.coin_reject, bus_b.busy, bus_b.pending} !== 7'd0) begin
      errors++;
      $display("FAIL reset_b: coin/rej/busy/pending %b, expected 0000000",
               {bus_b.coin, bus_b.coin_reject, bus_b.busy, bus_b.pending});
    end
`ifdef COIN_TALLY_EN
    checks++;
    if (bus_a.tally !== 16'd0) begin
      errors++;
      $display("FAIL reset_tally_a: got %0d expected 0", bus_a.tally);
    end
`endif
  endtask

  task automatic test_clean_5;
    int t;
    @(negedge clk);
    t = cyc;
    exp_coin_a.push_back(t + 21);
    bus_a.coin_in_5 = 1'b1;
    wait_cycle(t + 20);
    checks++;
    if (bus_a.pending !== 4'd1 || bus_a.busy !== 1'b1) begin
      errors++;
      $display("FAIL clean5_buffered: pending %0d busy %b, expected 1 and 1", bus_a.pending, bus_a.busy);
    end
    wait_cycle(t + 21);
    checks++;
    if (bus_a.pending !== 4'd0) begin
      errors++;
      $display("FAIL clean5_drained: pending %0d, expected 0", bus_a.pending);
    end
    wait_cycle(t + 40);
    bus_a.coin_in_5 = 1'b0;
    wait_cycle(t + 80);
    checks++;
    if (exp_coin_a.size() != 0) begin
      errors++;
      $display("FAIL clean5_missing: %0d pulses outstanding, expected 0", exp_coin_a.size());
    end
  endtask

  task automatic test_bounce;
    int t;
    logic [3:0] max_pend;
    logic       any_busy;
    @(negedge clk);
    t = cyc;
    max_pend = 4'd0;
    any_busy = 1'b0;
    for (int i = 0; i < 70; i++) begin
      wait_cycle(t + i);
      bus_a.coin_in_10 = (i < 30) && (((i / 3) % 2) == 0);
      if (bus_a.pending > max_pend) max_pend = bus_a.pending;
      any_busy = any_busy | bus_a.busy;
    end
    checks++;
    if (max_pend !== 4'd0 || any_busy !== 1'b0) begin
      errors++;
      $display("FAIL bounce_filter: max pending %0d busy seen %b, expected 0 and 0", max_pend, any_busy);
    end
  endtask

  task automatic test_10_split;
    int t;
    @(negedge clk);
    t = cyc;
    exp_coin_a.push_back(t + 21);
    exp_coin_a.push_back(t + 27);
    bus_a.coin_in_10 = 1'b1;
    wait_cycle(t + 20);
    checks++;
    if (bus_a.pending !== 4'd2) begin
      errors++;
      $display("FAIL split10_pending: got %0d expected 2", bus_a.pending);
    end
    wait_cycle(t + 31);
    checks++;
    if (bus_a.busy !== 1'b1) begin
      errors++;
      $display("FAIL split10_busy_gap: got %b expected 1", bus_a.busy);
    end
    wait_cycle(t + 32);
    checks++;
    if (bus_a.busy !== 1'b0 || bus_a.pending !== 4'd0) begin
      errors++;
      $display("FAIL split10_idle: busy %b pending %0d, expected 0 and 0", bus_a.busy, bus_a.pending);
    end
    wait_cycle(t + 40);
    bus_a.coin_in_10 = 1'b0;
    wait_cycle(t + 80);
    checks++;
    if (exp_coin_a.size() != 0) begin
      errors++;
      $display("FAIL split10_missing: %0d pulses outstanding, expected 0", exp_coin_a.size());
    end
  endtask

  // Fast instance: four 10-coins and a 5-coin back to back, then both slots together.
  task automatic test_overflow_simultaneous;
    int t;
    @(negedge clk);
    t = cyc;
    for (int k = 0; k < 9; k++) exp_coin_b.push_back(t + 6 + 17 * k);
    exp_rej_b.push_back(t + 11);
    exp_rej_b.push_back(t + 49);
    for (int i = 0; i < 8; i++) begin
      wait_cycle(t + i);
      bus_b.coin_in_10 = ((i % 2) == 0);
    end
    wait_cycle(t + 8);
    bus_b.coin_in_5 = 1'b1;
    wait_cycle(t + 9);
    bus_b.coin_in_5 = 1'b0;
    checks++;
    if (bus_b.pending !== 4'd5) begin
      errors++;
      $display("FAIL overflow_fill: pending %0d expected 5", bus_b.pending);
    end
    wait_cycle(t + 12);
    checks++;
    if (bus_b.pending !== 4'd5) begin
      errors++;
      $display("FAIL overflow_hold: pending %0d expected 5", bus_b.pending);
    end
    wait_cycle(t + 13);
    checks++;
    if (bus_b.pending !== 4'd6) begin
      errors++;
      $display("FAIL overflow_5coin: pending %0d expected 6", bus_b.pending);
    end
    wait_cycle(t + 44);
    checks++;
    if (bus_b.pending !== 4'd4) begin
      errors++;
      $display("FAIL simul_start: pending %0d expected 4", bus_b.pending);
    end
    bus_b.coin_in_5 = 1'b1;
    bus_b.coin_in_10 = 1'b1;
    wait_cycle(t + 45);
    bus_b.coin_in_5 = 1'b0;
    bus_b.coin_in_10 = 1'b0;
    wait_cycle(t + 49);
    checks++;
    if (bus_b.pending !== 4'd6) begin
      errors++;
      $display("FAIL simul_result: pending %0d expected 6", bus_b.pending);
    end
    wait_cycle(t + 157);
    checks++;
    if (bus_b.busy !== 1'b1) begin
      errors++;
      $display("FAIL drain_busy: got %b expected 1", bus_b.busy);
    end
    wait_cycle(t + 158);
    checks++;
    if (bus_b.busy !== 1'b0 || bus_b.pending !== 4'd0) begin
      errors++;
      $display("FAIL drain_idle: busy %b pending %0d, expected 0 and 0", bus_b.busy, bus_b.pending);
    end
    wait_cycle(t + 170);
    checks++;
    if (exp_coin_b.size() != 0 || exp_rej_b.size() != 0) begin
      errors++;
      $display("FAIL overflow_missing: %0d pulses, %0d rejects outstanding, expected 0 and 0",
               exp_coin_b.size(), exp_rej_b.size());
    end
`ifdef COIN_TALLY_EN
    checks++;
    if (bus_b.tally !== 16'd45 || bus_a.tally !== 16'd15) begin
      errors++;
      $display("FAIL tally: a %0d b %0d, expected 15 and 45", bus_a.tally, bus_b.tally);
    end
`endif
  endtask

  task automatic test_reset_midstream;
    int t;
    @(negedge clk);
    t = cyc;
    exp_coin_b.push_back(t + 6);
    for (int i = 0; i < 4; i++) begin
      wait_cycle(t + i);
      bus_b.coin_in_10 = ((i % 2) == 0);
    end
    wait_cycle(t + 8);
    checks++;
    if (bus_b.pending !== 4'd3 || bus_b.busy !== 1'b1) begin
      errors++;
      $display("FAIL midstream_setup: pending %0d busy %b, expected 3 and 1", bus_b.pending, bus_b.busy);
    end
    reset = 1'b1;
    wait_cycle(t + 9);
    reset = 1'b0;
    checks++;
    if ({bus_b.coin, bus_b.coin_reject, bus_b.busy, bus_b.pending} !== 7'd0) begin
      errors++;
      $display("FAIL midstream_reset: coin/rej/busy/pending %b, expected 0000000",
               {bus_b.coin, bus_b.coin_reject, bus_b.busy, bus_b.pending});
    end
`ifdef COIN_TALLY_EN
    checks++;
    if (bus_b.tally !== 16'd0) begin
      errors++;
      $display("FAIL midstream_tally: got %0d expected 0", bus_b.tally);
    end
`endif
    wait_cycle(t + 70);
    checks++;
    if (bus_b.pending !== 4'd0 || exp_coin_b.size() != 0) begin
      errors++;
      $display("FAIL midstream_quiet: pending %0d, %0d pulses outstanding, expected 0 and 0",
               bus_b.pending, exp_coin_b.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clean_5();
    test_bounce();
    test_10_split();
    test_overflow_simultaneous();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
